force_cache_wb_receiver: RTL
============================

# force_cache_wb_receiver

Receiving end of the force writeback bus. Accepts force packets (full particle ID plus x/y/z force) issued by force distributors, drops packets not addressed to this node's home cell, and accumulates forces per particle into a local force cache. On request, it dumps the accumulated cache to the motion-update stage and clears each entry as it is read.

## Interface
- CELL_ID_W, 9: width of the full cell ID (3 × 3-bit coordinates).
- PID_W, 6: particle index width within a cell.
- DEPTH, 64: force cache entries, equal to 2**PID_W.
- DATA_W, 32: signed two's-complement fixed-point width of each force component.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- home_cell_id  in  CELL_ID_W  cell ID owned by this node; stable outside reset.
- wb_in  in  CELL_ID_W+PID_W+3*DATA_W  packet {cell_id, pid, z, y, x}, MSB first.
- wb_valid  in  1  wb_in is valid this cycle.
- ready  out  1  receiver accepts a packet this cycle.
- dump_start  in  1  single-cycle request to dump and clear the cache.
- dump_valid  out  1  dump_pid and dump_force are valid.
- dump_pid  out  PID_W  entry index being dumped.
- dump_force  out  3*DATA_W  accumulated {z, y, x}.
- dump_done  out  1  pulse coincident with the last dump_valid.
- drop_count  out  16  count of dropped packets; saturates at 0xFFFF.
- sat_flag  out  1  sticky; set when any accumulation saturates.

## Operation
- Cache: one synchronous-read RAM with one write port, DEPTH × 3*DATA_W, no reset. Contents are zeroed by the CLEAR state.
- States:
  - CLEAR: entered on rst. Writes zero to addresses 0..DEPTH-1, one per cycle, then goes to ACCUM.
  - ACCUM: accepts packets normally.
  - DRAIN: lasts one cycle.
  - DUMP: reads out and clears the cache.
- Accept: wb_valid & ready.
  - If cell_id ≠ home_cell_id, the packet is dropped, drop_count increments, and the cache is untouched.
  - Otherwise the packet loads stage S1, and the RAM read of pid is issued at the same edge.
- S1: in the cycle after accept, S1 holds the packet and the read data. sum = operand + packet component, computed per component. sum is written to cache[pid] at the next edge.
- Forwarding: if the previous cycle's write targeted the same pid, operand = the registered last-written sum instead of RAM data. Back-to-back packets to the same pid must therefore accumulate exactly.
- Arithmetic: DATA_W-bit signed saturating add.
  - Positive overflow gives 2^(DATA_W-1)-1.
  - Negative overflow gives -2^(DATA_W-1).
  - Any saturation sets sat_flag, which clears only on rst.
- Dump sequence:
  - dump_start sampled in ACCUM moves to DRAIN; dump_start in any other state is ignored.
  - DRAIN lets S1 retire, then moves to DUMP.
  - DUMP issues read of address a and writes zero to a in the same cycle, for a = 0..DEPTH-1.
  - After address DEPTH-1 the block returns to ACCUM.
- ready = (state == ACCUM) & ~dump_start.

## Timing
- Reset values:
  - ready 0.
  - dump_valid 0 and dump_done 0.
  - drop_count 0 and sat_flag 0.
  - S1 empty; state CLEAR.
- CLEAR takes DEPTH cycles. ready rises in the first ACCUM cycle, which is cycle DEPTH+1 after rst deasserts.
- Throughput: one packet per cycle in ACCUM.
- Accumulation latency: a packet accepted at edge E0 is visible in the cache at E1.
- dump_start asserted in cycle k:
  - ready is low in cycle k, so no packet is accepted at that edge.
  - DRAIN is cycle k+1, and DUMP covers cycles k+2 .. k+DEPTH+1.
  - dump_valid for pid a appears in cycle k+3+a.
  - dump_done pulses in cycle k+DEPTH+2, which is also the first ACCUM cycle, so ready is high again.
- Ready protocol: senders must hold wb_valid and wb_in while ready is low. A packet presented while ready is low is not consumed.
- rst mid-DUMP or mid-accumulation: S1 is discarded, dump outputs drop immediately, and the block re-enters CLEAR. Cache contents are lost.
- drop_count holds at 0xFFFF.

## Test plan
- Reset with DEPTH=64: ready low for 64 cycles, then high. An immediate dump yields 64 entries of zero with dump_pid 0..63 and dump_done on pid 63.
- Two packets, pid 5 (x=10, y=-3, z=7), separated by 3 idle cycles, then a dump: pid 5 = {14, -6, 20}; all other entries 0.
- Three back-to-back packets to pid 3 with x = 1, 2, 3, then a dump: pid 3 x = 6 (exercises forwarding).
- Packet with cell_id = home_cell_id ^ 1: drop_count = 1, and the dump shows all zeros.
- Two packets to pid 0 with x = 0x7FFFFFF0 and x = 0x00000020: dumped x = 0x7FFFFFFF and sat_flag = 1. Repeat with negatives: x = 0x80000000.
- Continuous wb_valid stream while dump_start pulses: no packet is lost or duplicated (sum of dumps equals sum of sent), and a second dump right after returns all zeros.

Source files
------------

// File: rtl/force_cache_wb_receiver.sv
// force_cache_wb_receiver
//   Receiving end of the force writeback bus. Force packets addressed to this
//   node's home cell are accumulated per particle into a local force cache
//   using a signed saturating add; packets for other cells are counted and
//   dropped. On dump_start the cache is streamed out (one entry per cycle)
//   and each entry is zeroed as it is read.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   home_cell_id      cell owned by this node
//   wb_in/wb_valid    packet {cell_id, pid, z, y, x}, MSB first
//   ready             packet accepted when wb_valid & ready at a rising edge
//   dump_start        one-cycle request to dump and clear the cache
//   dump_valid/pid    dump stream qualifier and entry index
//   dump_force        accumulated {z, y, x} of entry dump_pid
//   dump_done         coincides with the last dump_valid
//   drop_count        saturating count of foreign-cell packets
//   sat_flag          sticky accumulation-saturation indicator
//   dbg_state         current FSM state
//
// Handshake: a packet transfers on a rising edge where wb_valid and ready are
// both high. ready never depends on wb_valid; while ready is low the sender
// holds wb_valid and wb_in unchanged and nothing is consumed.
module force_cache_wb_receiver #(
   parameter int CELL_ID_W = 9,
   parameter int PID_W     = 6,
   parameter int DEPTH     = 64,
   parameter int DATA_W    = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [CELL_ID_W-1:0]                home_cell_id,
   input  logic [CELL_ID_W+PID_W+3*DATA_W-1:0] wb_in,
   input  logic                                wb_valid,
   output logic                                ready,
   input  logic                                dump_start,
   output logic                                dump_valid,
   output logic [PID_W-1:0]                    dump_pid,
   output logic [3*DATA_W-1:0]                 dump_force,
   output logic                                dump_done,
   output logic [15:0]                         drop_count,
   output logic                                sat_flag,
   output logic [1:0]                          dbg_state
);
   localparam int FW = 3 * DATA_W;
   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DUMP  = 2'd3;
   localparam logic [PID_W-1:0] LAST_ADDR = PID_W'(DEPTH - 1);

   // packet fields
   logic [CELL_ID_W-1:0] in_cell;
   logic [PID_W-1:0]     in_pid;
   logic [FW-1:0]        in_force;
   assign in_force = wb_in[FW-1:0];
   assign in_pid   = wb_in[FW +: PID_W];
   assign in_cell  = wb_in[FW+PID_W +: CELL_ID_W];

   // cache RAM: one write port, registered read returning pre-write data
   logic [FW-1:0]    cache_mem [DEPTH];
   logic [FW-1:0]    rd_data_q;
   logic             mem_we;
   logic [PID_W-1:0] mem_waddr;
   logic [PID_W-1:0] mem_raddr;
   logic [FW-1:0]    mem_wdata;

   always_ff @(posedge clk) begin
      if (mem_we) cache_mem[mem_waddr] <= mem_wdata;
      rd_data_q <= cache_mem[mem_raddr];
   end

   logic [1:0]       state_q, state_d;
   logic [PID_W-1:0] addr_q, addr_d;
   logic             s1_valid_q, s1_valid_d;
   logic [PID_W-1:0] s1_pid_q, s1_pid_d;
   logic [FW-1:0]    s1_force_q, s1_force_d;
   logic             last_valid_q, last_valid_d;
   logic [PID_W-1:0] last_pid_q, last_pid_d;
   logic [FW-1:0]    last_sum_q, last_sum_d;
   logic [15:0]      drop_count_q, drop_count_d;
   logic             sat_flag_q, sat_flag_d;
   logic             dump_valid_q, dump_valid_d;
   logic [PID_W-1:0] dump_pid_q, dump_pid_d;
   logic             dump_done_q, dump_done_d;

   logic [FW-1:0] operand;
   logic [FW-1:0] sum;
   logic          any_sat;

   // returns {overflow, saturated sum}
   function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] s;
      logic              ovf;
      s   = a + b;
      ovf = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
      if (ovf) s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      return {ovf, s};
   endfunction

   // The RAM read for this S1 packet was issued while the previous packet's
   // write was still in flight; if that write hit the same pid, take its sum.
   always_comb begin
      logic [DATA_W:0] r;
      operand = (last_valid_q && (last_pid_q == s1_pid_q)) ? last_sum_q : rd_data_q;
      sum     = '0;
      any_sat = 1'b0;
      for (int c = 0; c < 3; c++) begin
         r = sat_add(operand[c*DATA_W +: DATA_W], s1_force_q[c*DATA_W +: DATA_W]);
         sum[c*DATA_W +: DATA_W] = r[DATA_W-1:0];
         any_sat = any_sat | r[DATA_W];
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      s1_valid_d   = 1'b0;
      s1_pid_d     = s1_pid_q;
      s1_force_d   = s1_force_q;
      last_valid_d = 1'b0;
      last_pid_d   = last_pid_q;
      last_sum_d   = last_sum_q;
      drop_count_d = drop_count_q;
      sat_flag_d   = sat_flag_q;
      dump_valid_d = 1'b0;
      dump_pid_d   = dump_pid_q;
      dump_done_d  = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = addr_q;
      mem_wdata    = '0;
      mem_raddr    = in_pid;
      ready        = (state_q == ST_ACCUM) && !dump_start;

      // S1 retire; S1 is only ever occupied in ACCUM or the DRAIN cycle
      if (s1_valid_q) begin
         mem_we       = 1'b1;
         mem_waddr    = s1_pid_q;
         mem_wdata    = sum;
         last_valid_d = 1'b1;
         last_pid_d   = s1_pid_q;
         last_sum_d   = sum;
         sat_flag_d   = sat_flag_q | any_sat;
      end

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = '0;
            addr_d    = addr_q + PID_W'(1);
            if (addr_q == LAST_ADDR) state_d = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (dump_start) begin
               state_d = ST_DRAIN;
            end else if (wb_valid) begin
               if (in_cell == home_cell_id) begin
                  s1_valid_d = 1'b1;
                  s1_pid_d   = in_pid;
                  s1_force_d = in_force;
               end else if (drop_count_q != 16'hFFFF) begin
                  drop_count_d = drop_count_q + 16'd1;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_DUMP;
            addr_d  = '0;
         end
         ST_DUMP: begin
            // read-before-write RAM: the read returns the old entry
            mem_we       = 1'b1;
            mem_waddr    = addr_q;
            mem_wdata    = '0;
            mem_raddr    = addr_q;
            dump_valid_d = 1'b1;
            dump_pid_d   = addr_q;
            dump_done_d  = (addr_q == LAST_ADDR);
            addr_d       = addr_q + PID_W'(1);
            if (addr_q == LAST_ADDR) state_d = ST_ACCUM;
         end
         default: state_d = ST_CLEAR;
      endcase

      // reset discards any in-flight S1 write
      mem_we = mem_we & ~rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CLEAR;
         addr_q       <= '0;
         s1_valid_q   <= 1'b0;
         last_valid_q <= 1'b0;
         drop_count_q <= '0;
         sat_flag_q   <= 1'b0;
         dump_valid_q <= 1'b0;
         dump_pid_q   <= '0;
         dump_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         s1_valid_q   <= s1_valid_d;
         last_valid_q <= last_valid_d;
         drop_count_q <= drop_count_d;
         sat_flag_q   <= sat_flag_d;
         dump_valid_q <= dump_valid_d;
         dump_pid_q   <= dump_pid_d;
         dump_done_q  <= dump_done_d;
      end
   end

   // datapath registers are qualified by the valid flags above
   always_ff @(posedge clk) begin
      s1_pid_q   <= s1_pid_d;
      s1_force_q <= s1_force_d;
      last_pid_q <= last_pid_d;
      last_sum_q <= last_sum_d;
   end

   assign dump_valid = dump_valid_q;
   assign dump_pid   = dump_pid_q;
   assign dump_force = rd_data_q;
   assign dump_done  = dump_done_q;
   assign drop_count = drop_count_q;
   assign sat_flag   = sat_flag_q;
   assign dbg_state  = state_q;

endmodule
